// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Computes ALU results, operand-B and destination selects, and the branch
// target/taken. All results are registered into the EX/MEM register.
// Build option EX_MULT_EN: adds an iterative shift-add multiplier (funct
// 011000) that stalls the front of the pipe. Without the macro that funct
// code is treated as undefined and stall_out is tied low.
module ex_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] dr1,
  input  logic [WIDTH-1:0] dr2,
  input  logic [WIDTH-1:0] sign,
  input  logic [4:0]       AW,
  input  logic [4:0]       Inm,
  input  logic [5:0]       sel,
  input  logic [WIDTH-1:0] cuatro,
  input  logic [2:0]       aluop,
  input  logic             regdst,
  input  logic             alusrc,
  input  logic             regwrite,
  input  logic             memtoreg,
  input  logic             er,
  input  logic             ew,
  input  logic             pcsrc,
  input  logic             jump,
  output logic             stall_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] wd_out,
  output logic [4:0]       wa_out,
  output logic             regwrite_out,
  output logic             memtoreg_out,
  output logic             er_out,
  output logic             ew_out,
  output logic             jump_out,
  output logic             br_taken_out,
  output logic [WIDTH-1:0] br_target_out
);

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wd;
    logic [4:0]       wa;
    logic             regwrite;
    logic             memtoreg;
    logic             er;
    logic             ew;
    logic             jump;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
  } exmem_t;

  // The shift-add loop retires one multiplier bit per iteration.
  if (MUL_CYCLES != WIDTH) begin : g_cfg_chk
    $error("ex_stage: MUL_CYCLES must equal WIDTH");
  end

  logic [WIDTH-1:0] b_op, diff, alu_res, ex_res;
  logic             zero, bubble;
  exmem_t           exmem_d, exmem_q;

  assign b_op = alusrc ? sign : dr2;
  assign diff = dr1 - b_op;
  assign zero = (diff == '0);

`ifdef EX_MULT_EN
  logic is_mult;
`endif

  // ALU decode; unknown codes produce 0 but keep the controls flowing.
  always_comb begin
    alu_res = '0;
`ifdef EX_MULT_EN
    is_mult = 1'b0;
`endif
    case (aluop)
      3'b000: alu_res = dr1 + b_op;
      3'b001: alu_res = diff;
      3'b011: alu_res = dr1 & b_op;
      3'b100: alu_res = dr1 | b_op;
      3'b101: alu_res[0] = $signed(dr1) < $signed(b_op);
      3'b010: begin
        case (sel)
          6'b100000: alu_res = dr1 + b_op;
          6'b100010: alu_res = diff;
          6'b100100: alu_res = dr1 & b_op;
          6'b100101: alu_res = dr1 | b_op;
          6'b101010: alu_res[0] = $signed(dr1) < $signed(b_op);
`ifdef EX_MULT_EN
          6'b011000: is_mult = 1'b1;
`endif
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULT_EN
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    cnt;
  logic             stall_c, use_acc;

  // Multiplier sequencing: stall from the decode cycle through the last
  // iteration, then release the product together with the held controls.
  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    bubble   = 1'b0;
    use_acc  = 1'b0;
    case (state)
      IDLE: if (is_mult) begin
        stall_c  = 1'b1;
        bubble   = 1'b1;
        state_nx = MUL;
      end
      MUL: begin
        stall_c = 1'b1;
        bubble  = 1'b1;
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        use_acc  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus shift-add datapath; flush aborts the multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (is_mult) begin
          mcand  <= dr1;
          mplier <= b_op;
          acc    <= '0;
          cnt    <= CW'(MUL_CYCLES);
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign stall_out = stall_c & ~flush & ~rst;
  assign ex_res    = use_acc ? acc : alu_res;
`else
  assign stall_out = 1'b0;
  assign bubble    = 1'b0;
  assign ex_res    = alu_res;
`endif

  // Next EX/MEM contents; a bubble carries no controls and zero data.
  always_comb begin
    exmem_d = '0;
    if (!bubble) begin
      exmem_d.alu       = ex_res;
      exmem_d.wd        = dr2;
      exmem_d.wa        = regdst ? Inm : AW;
      exmem_d.regwrite  = regwrite;
      exmem_d.memtoreg  = memtoreg;
      exmem_d.er        = er;
      exmem_d.ew        = ew;
      exmem_d.jump      = jump;
      exmem_d.br_taken  = pcsrc & zero;
      exmem_d.br_target = cuatro + (sign << 2);
    end
  end

  // EX/MEM pipeline register; flush clears it like a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        exmem_q <= '0;
    else if (flush) exmem_q <= '0;
    else            exmem_q <= exmem_d;
  end

  assign alu_out       = exmem_q.alu;
  assign wd_out        = exmem_q.wd;
  assign wa_out        = exmem_q.wa;
  assign regwrite_out  = exmem_q.regwrite;
  assign memtoreg_out  = exmem_q.memtoreg;
  assign er_out        = exmem_q.er;
  assign ew_out        = exmem_q.ew;
  assign jump_out      = exmem_q.jump;
  assign br_taken_out  = exmem_q.br_taken;
  assign br_target_out = exmem_q.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes per-cycle expected stall
// and EX/MEM contents from a behavioural model; a negedge monitor compares.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        rw, m2r, er, ew, jmp, bt;
    logic [31:0] tgt;
  } exm_t;

  typedef struct {
    logic [31:0] dr1, dr2, sign, cuatro;
    logic [4:0]  aw, inm;
    logic [5:0]  sel;
    logic [2:0]  aluop;
    logic        regdst, alusrc, regwrite, memtoreg, er, ew, pcsrc, jump;
  } stim_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [31:0] dr1 = '0, dr2 = '0, sign = '0, cuatro = '0;
  logic [4:0]  AW = '0, Inm = '0;
  logic [5:0]  sel = '0;
  logic [2:0]  aluop = '0;
  logic        regdst = 0, alusrc = 0, regwrite = 0, memtoreg = 0;
  logic        er = 0, ew = 0, pcsrc = 0, jump = 0;
  logic        stall_out;
  logic [31:0] alu_out, wd_out, br_target_out;
  logic [4:0]  wa_out;
  logic        regwrite_out, memtoreg_out, er_out, ew_out, jump_out, br_taken_out;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .dr1(dr1), .dr2(dr2), .sign(sign),
    .AW(AW), .Inm(Inm), .sel(sel), .cuatro(cuatro), .aluop(aluop),
    .regdst(regdst), .alusrc(alusrc), .regwrite(regwrite), .memtoreg(memtoreg),
    .er(er), .ew(ew), .pcsrc(pcsrc), .jump(jump), .stall_out(stall_out),
    .alu_out(alu_out), .wd_out(wd_out), .wa_out(wa_out),
    .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out), .er_out(er_out),
    .ew_out(ew_out), .jump_out(jump_out), .br_taken_out(br_taken_out),
    .br_target_out(br_target_out)
  );

  always #5 clk = ~clk;

  exm_t out_q[$];
  bit   stall_q[$];
  int   vecs = 0, errs = 0;
  int   mul_ph = 0;   // cycles the current multiply has been held

  function automatic bit is_mult(input stim_t s);
`ifdef EX_MULT_EN
    return (s.aluop == 3'b010) && (s.sel == 6'b011000);
`else
    return 1'b0;
`endif
  endfunction

  // Architectural result of one instruction.
  function automatic exm_t model(input stim_t s);
    exm_t        e;
    logic [31:0] b;
    b = s.alusrc ? s.sign : s.dr2;
    e = '0;
    case (s.aluop)
      3'd0: e.alu = s.dr1 + b;
      3'd1: e.alu = s.dr1 - b;
      3'd3: e.alu = s.dr1 & b;
      3'd4: e.alu = s.dr1 | b;
      3'd5: e.alu = (int'(s.dr1) < int'(b)) ? 32'd1 : 32'd0;
      3'd2: case (s.sel)
        6'h20: e.alu = s.dr1 + b;
        6'h22: e.alu = s.dr1 - b;
        6'h24: e.alu = s.dr1 & b;
        6'h25: e.alu = s.dr1 | b;
        6'h2A: e.alu = (int'(s.dr1) < int'(b)) ? 32'd1 : 32'd0;
        6'h18: e.alu = is_mult(s) ? s.dr1 * b : 32'd0;
        default: e.alu = 32'd0;
      endcase
      default: e.alu = 32'd0;
    endcase
    e.wd  = s.dr2;
    e.wa  = s.regdst ? s.inm : s.aw;
    e.rw  = s.regwrite; e.m2r = s.memtoreg; e.er = s.er; e.ew = s.ew;
    e.jmp = s.jump;
    e.bt  = s.pcsrc && (s.dr1 == b);
    e.tgt = s.cuatro + (s.sign << 2);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    dr1 = s.dr1; dr2 = s.dr2; sign = s.sign; cuatro = s.cuatro;
    AW = s.aw; Inm = s.inm; sel = s.sel; aluop = s.aluop;
    regdst = s.regdst; alusrc = s.alusrc; regwrite = s.regwrite;
    memtoreg = s.memtoreg; er = s.er; ew = s.ew; pcsrc = s.pcsrc; jump = s.jump;
  endtask

  // One pipeline cycle of stimulus; a multiply is 33 stalled cycles then
  // its product, and a flush kills everything in flight.
  task automatic apply(input stim_t s, input logic f);
    @(posedge clk); #1;
    drive(s); rst = 1'b0; flush = f;
    if (f) begin
      stall_q.push_back(1'b0); out_q.push_back('0); mul_ph = 0;
    end else if (is_mult(s)) begin
      if (mul_ph == 33) begin
        stall_q.push_back(1'b0); out_q.push_back(model(s)); mul_ph = 0;
      end else begin
        stall_q.push_back(1'b1); out_q.push_back('0); mul_ph++;
      end
    end else begin
      stall_q.push_back(1'b0); out_q.push_back(model(s));
    end
  endtask

  // Reset held for a whole cycle (power-on style).
  task automatic hold_rst();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0;
    stall_q.push_back(1'b0); out_q.push_back('0); mul_ph = 0;
  endtask

  // Reset raised asynchronously in the middle of a cycle.
  task automatic reset_mid();
    @(posedge clk); #1;
    flush = 1'b0;
    stall_q.push_back(1'b0); out_q.push_back('0); mul_ph = 0;
    #2 rst = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    logic [5:0] sels [7];
    sels = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h3F};
    s.dr1 = $urandom; s.dr2 = $urandom; s.sign = $urandom; s.cuatro = $urandom;
    if ($urandom_range(0, 3) == 0) s.dr2 = s.dr1;
    s.aw = 5'($urandom); s.inm = 5'($urandom);
    s.sel = sels[$urandom_range(0, 6)];
    s.aluop = 3'($urandom);
    {s.regdst, s.alusrc, s.regwrite, s.memtoreg} = 4'($urandom);
    {s.er, s.ew, s.pcsrc, s.jump} = 4'($urandom);
    return s;
  endfunction

  // Monitor: outputs after each edge vs. the previous cycle's expectation,
  // stall_out vs. the current cycle's expectation.
  initial begin : mon
    exm_t act, exp_o, pend;
    bit   have, es;
    have = 1'b0;
    forever begin
      @(negedge clk);
      act = {alu_out, wd_out, wa_out, regwrite_out, memtoreg_out, er_out,
             ew_out, jump_out, br_taken_out, br_target_out};
      if (have) begin
        exp_o = rst ? exm_t'('0) : pend;
        vecs++;
        if (act !== exp_o) begin
          errs++;
          $display("FAIL exmem @%0t: got %h want %h", $time, act, exp_o);
        end
        have = 1'b0;
      end
      if (stall_q.size() != 0) begin
        es = stall_q.pop_front();
        vecs++;
        if (stall_out !== es) begin
          errs++;
          $display("FAIL stall @%0t: got %b want %b", $time, stall_out, es);
        end
        pend = out_q.pop_front();
        have = 1'b1;
      end
    end
  end

  initial begin : drv
    stim_t s, m;
    hold_rst(); hold_rst();

    // R-type sub with rd destination
    s = rand_stim();
    s.aluop = 3'b010; s.sel = 6'b100010; s.dr1 = 5; s.dr2 = 7; s.alusrc = 0;
    s.regdst = 1; s.inm = 9; s.regwrite = 1;
    apply(s, 0);
    // equal operands, branch taken, negative offset
    s = rand_stim();
    s.aluop = 3'b001; s.dr1 = 32'h1234; s.dr2 = 32'h1234; s.alusrc = 0;
    s.pcsrc = 1; s.cuatro = 32'h100; s.sign = 32'hFFFF_FFFE;
    apply(s, 0);
    // add wrap through the immediate path
    s = rand_stim();
    s.aluop = 3'b000; s.alusrc = 1; s.dr1 = 32'hFFFF_FFFF; s.sign = 1;
    apply(s, 0);
    // signed slt with most-negative operand
    s = rand_stim();
    s.aluop = 3'b101; s.alusrc = 0; s.dr1 = 32'h8000_0000; s.dr2 = 1;
    apply(s, 0);
    // undefined aluop passes controls with result 0
    s = rand_stim(); s.aluop = 3'b111;
    apply(s, 0);
    // asynchronous reset right after a live instruction
    reset_mid();

    // full multiply
    m = rand_stim();
    m.aluop = 3'b010; m.sel = 6'b011000; m.alusrc = 0;
    m.dr1 = 32'h0001_0000; m.dr2 = 32'h0001_0003; m.regwrite = 1;
    do apply(m, 0); while (mul_ph != 0);
    apply(rand_stim(), 0);

    // flush in the middle of the multiply
    repeat (11) apply(m, 0);
    apply(m, 1);
    s = rand_stim(); s.aluop = 3'b000;
    apply(s, 0);

    // reset in the middle of the multiply
    repeat (7) apply(m, 0);
    reset_mid();
    s = rand_stim(); s.aluop = 3'b100;
    apply(s, 0);

    // random traffic, multiplies held until they complete
    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      if (i % 50 == 25) begin
        s.aluop = 3'b010; s.sel = 6'b011000;
      end
      do apply(s, 0); while (mul_ph != 0);
      if (i % 97 == 50) reset_mid();
      else if (i % 89 == 40) apply(rand_stim(), 1);
    end

    s = rand_stim(); s.aluop = 3'b000;
    apply(s, 0);
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
